uart_mmio_peripheral: RTL and testbench

- Memory-mapped UART responder on the CPU data bus, at the peripheral window starting at 0x40000018.
- It serves the three registers software uses for serial I/O:
  - TXD at BASE+0x0
  - RXD at BASE+0x4
  - UART_CON at BASE+0x8
- It receives 8N1 bytes on the serial line for software to poll and read, and transmits bytes that software writes.
- It sits beside the timer/LED/digit peripherals. Its read data is muxed into the CPU load path when `sel` is high.

---
 rtl/uart_mmio_peripheral_pkg.sv | 29 ++
 rtl/uart_mmio_peripheral_rx.sv | 103 ++++++++++
 rtl/uart_mmio_peripheral.sv | 218 +++++++++++++++++++++
 tb/tb_uart_mmio_peripheral.sv | 318 +++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/uart_mmio_peripheral_pkg.sv
// Shared definitions for the memory-mapped UART: register offsets, status bit
// positions and the frame state encoding used by both RX and TX engines.
package uart_mmio_peripheral_pkg;

    localparam int unsigned OVERSAMPLE = 16;

    localparam logic [31:0] OFS_TXD = 32'h0;
    localparam logic [31:0] OFS_RXD = 32'h4;
    localparam logic [31:0] OFS_CON = 32'h8;

    localparam int unsigned AVAIL0 = 0;
    localparam int unsigned AVAIL1 = 1;
    localparam int unsigned TXBUSY = 2;
    localparam int unsigned OVR    = 3;
    localparam int unsigned FERR   = 4;

    typedef enum logic [1:0] {
        StIdle,
        StStart,
        StData,
        StStop
    } uart_state_e;

    // Word-granular compare; the byte lane bits never take part in decode.
    function automatic logic word_hit(input logic [31:0] addr, input logic [31:0] reg_addr);
        return addr[31:2] == reg_addr[31:2];
    endfunction

endpackage

// File: rtl/uart_mmio_peripheral_rx.sv
// 8N1 receiver: 2-flop synchronizer, 16x oversampled frame FSM and shift register.
// Emits single-cycle pulses for a good byte or a framing error.
module uart_rx_core
    import uart_mmio_peripheral_pkg::*;
(
    input  logic       clk,
    input  logic       reset,
    input  logic       tick,
    input  logic       rxd,
    output logic       byte_valid,
    output logic [7:0] byte_data,
    output logic       frame_err
);

    localparam logic [3:0] HalfCnt = 4'(OVERSAMPLE / 2 - 1);
    localparam logic [3:0] LastCnt = 4'(OVERSAMPLE - 1);

    logic        sync1_q, sync2_q;
    uart_state_e state_q, state_d;
    logic [3:0]  cnt_q, cnt_d;
    logic [2:0]  bit_q, bit_d;
    logic [7:0]  shift_q, shift_d;

    always_ff @(posedge clk) begin
        if (reset) begin
            sync1_q <= 1'b1;
            sync2_q <= 1'b1;
            state_q <= StIdle;
            cnt_q   <= 4'd0;
            bit_q   <= 3'd0;
            shift_q <= 8'd0;
        end else begin
            sync1_q <= rxd;
            sync2_q <= sync1_q;
            state_q <= state_d;
            cnt_q   <= cnt_d;
            bit_q   <= bit_d;
            shift_q <= shift_d;
        end
    end

    always_comb begin
        state_d    = state_q;
        cnt_d      = cnt_q;
        bit_d      = bit_q;
        shift_d    = shift_q;
        byte_valid = 1'b0;
        frame_err  = 1'b0;
        case (state_q)
            StIdle: begin
                if (!sync2_q) begin
                    state_d = StStart;
                    cnt_d   = 4'd0;
                end
            end
            StStart: begin
                // Mid-start check rejects glitches shorter than half a bit.
                if (tick) begin
                    if (cnt_q == HalfCnt) begin
                        if (sync2_q) begin
                            state_d = StIdle;
                        end else begin
                            state_d = StData;
                            cnt_d   = 4'd0;
                            bit_d   = 3'd0;
                        end
                    end else begin
                        cnt_d = cnt_q + 4'd1;
                    end
                end
            end
            StData: begin
                if (tick) begin
                    if (cnt_q == LastCnt) begin
                        cnt_d   = 4'd0;
                        shift_d = {sync2_q, shift_q[7:1]};
                        bit_d   = bit_q + 3'd1;
                        if (bit_q == 3'd7) begin
                            state_d = StStop;
                        end
                    end else begin
                        cnt_d = cnt_q + 4'd1;
                    end
                end
            end
            StStop: begin
                if (tick) begin
                    if (cnt_q == LastCnt) begin
                        state_d    = StIdle;
                        byte_valid = sync2_q;
                        frame_err  = !sync2_q;
                    end else begin
                        cnt_d = cnt_q + 4'd1;
                    end
                end
            end
            default: state_d = StIdle;
        endcase
    end

    assign byte_data = shift_q;

endmodule

// File: rtl/uart_mmio_peripheral.sv
// Bus-facing UART: TXD/RXD/UART_CON register file, baud tick generator and
// 8N1 transmitter; reception is delegated to uart_rx_core.
module uart_mmio_peripheral
    import uart_mmio_peripheral_pkg::*;
#(
    parameter int unsigned CLK_FREQ  = 100000000,
    parameter int unsigned BAUD      = 9600,
    parameter logic [31:0] BASE_ADDR = 32'h40000018
) (
    input  logic        clk,
    input  logic        reset,
    input  logic [31:0] addr,
    input  logic [31:0] wdata,
    input  logic        MemRead,
    input  logic        MemWrite,
    output logic [31:0] rdata,
    output logic        sel,
    input  logic        uart_rxd,
    output logic        uart_txd
);

    localparam int unsigned DIV  = (CLK_FREQ + BAUD * OVERSAMPLE / 2) / (BAUD * OVERSAMPLE);
    localparam int unsigned CntW = (DIV > 1) ? $clog2(DIV) : 1;
    localparam logic [CntW-1:0] DivLast = CntW'(DIV - 1);
    localparam logic [3:0]      LastCnt = 4'(OVERSAMPLE - 1);

    localparam logic [31:0] AddrTxd = BASE_ADDR + OFS_TXD;
    localparam logic [31:0] AddrRxd = BASE_ADDR + OFS_RXD;
    localparam logic [31:0] AddrCon = BASE_ADDR + OFS_CON;

    logic [CntW-1:0] div_cnt_q, div_cnt_d;
    logic            tick;

    uart_state_e tx_state_q, tx_state_d;
    logic [3:0]  tx_cnt_q, tx_cnt_d;
    logic [2:0]  tx_bit_q, tx_bit_d;
    logic [7:0]  tx_last_q, tx_last_d;
    logic        tx_busy_q, tx_busy_d;
    logic        txd_q, txd_d;

    logic [7:0] rx_byte_q, rx_byte_d;
    logic       rx_avail_q, rx_avail_d;
    logic       ovr_q, ovr_d;
    logic       ferr_q, ferr_d;

    logic       hit_txd, hit_rxd, hit_con;
    logic       rxd_rd, con_wr, tx_wr;
    logic       byte_valid, frame_err;
    logic [7:0] rx_new;
    logic [31:0] con_val;
    logic       unused_bits;

    assign hit_txd = word_hit(addr, AddrTxd);
    assign hit_rxd = word_hit(addr, AddrRxd);
    assign hit_con = word_hit(addr, AddrCon);
    assign sel     = hit_txd | hit_rxd | hit_con;
    assign rxd_rd  = MemRead & hit_rxd;
    assign con_wr  = MemWrite & hit_con;
    assign tx_wr   = MemWrite & hit_txd;
    assign tick    = (div_cnt_q == DivLast);

    assign unused_bits = ^{addr[1:0], wdata[31:8]};

    uart_rx_core u_rx (
        .clk        (clk),
        .reset      (reset),
        .tick       (tick),
        .rxd        (uart_rxd),
        .byte_valid (byte_valid),
        .byte_data  (rx_new),
        .frame_err  (frame_err)
    );

    always_ff @(posedge clk) begin
        if (reset) begin
            div_cnt_q  <= '0;
            tx_state_q <= StIdle;
            tx_cnt_q   <= 4'd0;
            tx_bit_q   <= 3'd0;
            tx_last_q  <= 8'd0;
            tx_busy_q  <= 1'b0;
            txd_q      <= 1'b1;
            rx_byte_q  <= 8'd0;
            rx_avail_q <= 1'b0;
            ovr_q      <= 1'b0;
            ferr_q     <= 1'b0;
        end else begin
            div_cnt_q  <= div_cnt_d;
            tx_state_q <= tx_state_d;
            tx_cnt_q   <= tx_cnt_d;
            tx_bit_q   <= tx_bit_d;
            tx_last_q  <= tx_last_d;
            tx_busy_q  <= tx_busy_d;
            txd_q      <= txd_d;
            rx_byte_q  <= rx_byte_d;
            rx_avail_q <= rx_avail_d;
            ovr_q      <= ovr_d;
            ferr_q     <= ferr_d;
        end
    end

    always_comb begin
        div_cnt_d  = tick ? '0 : div_cnt_q + CntW'(1);
        tx_state_d = tx_state_q;
        tx_cnt_d   = tx_cnt_q;
        tx_bit_d   = tx_bit_q;
        tx_last_d  = tx_last_q;
        tx_busy_d  = tx_busy_q;
        txd_d      = txd_q;

        if (tx_wr && !tx_busy_q) begin
            tx_last_d = wdata[7:0];
            tx_busy_d = 1'b1;
        end

        // tx_last doubles as the shift source since it is frozen while busy.
        case (tx_state_q)
            StIdle: begin
                if (tx_busy_q && tick) begin
                    tx_state_d = StStart;
                    tx_cnt_d   = 4'd0;
                    txd_d      = 1'b0;
                end
            end
            StStart: begin
                if (tick) begin
                    if (tx_cnt_q == LastCnt) begin
                        tx_state_d = StData;
                        tx_cnt_d   = 4'd0;
                        tx_bit_d   = 3'd0;
                        txd_d      = tx_last_q[0];
                    end else begin
                        tx_cnt_d = tx_cnt_q + 4'd1;
                    end
                end
            end
            StData: begin
                if (tick) begin
                    if (tx_cnt_q == LastCnt) begin
                        tx_cnt_d = 4'd0;
                        if (tx_bit_q == 3'd7) begin
                            tx_state_d = StStop;
                            txd_d      = 1'b1;
                        end else begin
                            tx_bit_d = tx_bit_q + 3'd1;
                            txd_d    = tx_last_q[tx_bit_q + 3'd1];
                        end
                    end else begin
                        tx_cnt_d = tx_cnt_q + 4'd1;
                    end
                end
            end
            StStop: begin
                if (tick) begin
                    if (tx_cnt_q == LastCnt) begin
                        tx_state_d = StIdle;
                        tx_busy_d  = 1'b0;
                    end else begin
                        tx_cnt_d = tx_cnt_q + 4'd1;
                    end
                end
            end
            default: tx_state_d = StIdle;
        endcase
    end

    always_comb begin
        rx_byte_d  = rx_byte_q;
        rx_avail_d = rx_avail_q;
        ovr_d      = ovr_q;
        ferr_d     = ferr_q;

        if (rxd_rd) begin
            rx_avail_d = 1'b0;
        end
        // A pop on the same edge makes room, so the new byte lands without overrun.
        if (byte_valid) begin
            if (!rx_avail_q || rxd_rd) begin
                rx_byte_d  = rx_new;
                rx_avail_d = 1'b1;
            end
        end

        if (con_wr && wdata[OVR]) begin
            ovr_d = 1'b0;
        end
        if (byte_valid && rx_avail_q && !rxd_rd) begin
            ovr_d = 1'b1;
        end
        if (con_wr && wdata[FERR]) begin
            ferr_d = 1'b0;
        end
        if (frame_err) begin
            ferr_d = 1'b1;
        end
    end

    always_comb begin
        con_val         = '0;
        con_val[AVAIL0] = rx_avail_q;
        con_val[AVAIL1] = rx_avail_q;
        con_val[TXBUSY] = tx_busy_q;
        con_val[OVR]    = ovr_q;
        con_val[FERR]   = ferr_q;

        rdata = '0;
        if (hit_txd) begin
            rdata = {24'd0, tx_last_q};
        end else if (hit_rxd) begin
            rdata = {24'd0, rx_byte_q};
        end else if (hit_con) begin
            rdata = con_val;
        end
    end

    assign uart_txd = txd_q;

endmodule

// File: tb/tb_uart_mmio_peripheral.sv
// Self-checking bench for uart_mmio_peripheral: decode table, directed frame
// scenarios, and randomized RX/TX traffic against a byte-level model.
module tb_uart_mmio_peripheral;

    localparam int unsigned BIT_CLKS = 160;
    localparam logic [31:0] A_TXD = 32'h40000018;
    localparam logic [31:0] A_RXD = 32'h4000001C;
    localparam logic [31:0] A_CON = 32'h40000020;

    logic        clk = 1'b0;
    logic        reset = 1'b1;
    logic [31:0] addr = '0;
    logic [31:0] wdata = '0;
    logic        MemRead = 1'b0;
    logic        MemWrite = 1'b0;
    logic [31:0] rdata;
    logic        sel;
    logic        uart_rxd;
    logic        uart_txd;
    logic        rxd_drv = 1'b1;
    logic        loop_en = 1'b0;

    int total = 0;
    int bad = 0;

    assign uart_rxd = loop_en ? uart_txd : rxd_drv;

    always #5 clk = ~clk;

    uart_mmio_peripheral #(
        .CLK_FREQ  (1600000),
        .BAUD      (10000),
        .BASE_ADDR (32'h40000018)
    ) dut (
        .clk      (clk),
        .reset    (reset),
        .addr     (addr),
        .wdata    (wdata),
        .MemRead  (MemRead),
        .MemWrite (MemWrite),
        .rdata    (rdata),
        .sel      (sel),
        .uart_rxd (uart_rxd),
        .uart_txd (uart_txd)
    );

    task automatic check(input string name, input logic [31:0] got, input logic [31:0] exp);
        total++;
        if (got !== exp) begin
            bad++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", name, got, exp);
        end
    endtask

    task automatic wait_clks(input int n);
        repeat (n) @(negedge clk);
    endtask

    task automatic bus_wr(input logic [31:0] a, input logic [31:0] d);
        @(negedge clk);
        addr = a; wdata = d; MemWrite = 1'b1;
        @(negedge clk);
        MemWrite = 1'b0; addr = '0; wdata = '0;
    endtask

    task automatic bus_rd(input logic [31:0] a, output logic [31:0] d);
        @(negedge clk);
        addr = a; MemRead = 1'b1;
        #1 d = rdata;
        @(negedge clk);
        MemRead = 1'b0; addr = '0;
    endtask

    task automatic rd_check(input string name, input logic [31:0] a, input logic [31:0] exp);
        logic [31:0] d;
        bus_rd(a, d);
        check(name, d, exp);
    endtask

    // Drives one 8N1 frame; a bad stop bit is held low past the receiver's sample point.
    task automatic send_rx(input logic [7:0] b, input bit bad_stop);
        rxd_drv = 1'b0;
        wait_clks(BIT_CLKS);
        for (int i = 0; i < 8; i++) begin
            rxd_drv = b[i];
            wait_clks(BIT_CLKS);
        end
        if (bad_stop) begin
            rxd_drv = 1'b0;
            wait_clks(100);
            rxd_drv = 1'b1;
            wait_clks(60);
        end else begin
            rxd_drv = 1'b1;
            wait_clks(BIT_CLKS);
        end
    endtask

    task automatic wait_tx_idle(input string name);
        logic [31:0] d;
        int n;
        n = 0;
        d = 32'h4;
        while (d[2] && n < 2000) begin
            bus_rd(A_CON, d);
            n++;
        end
        if (d[2]) begin
            total++;
            bad++;
            $display("FAIL %s: tx_busy still set after %0d polls", name, n);
        end
    endtask

    // Line-level model of a UART receiver watching uart_txd; records {frame_ok, byte}.
    logic [8:0] tx_q[$];
    logic [7:0] mon_b;
    logic       mon_ok;
    always begin
        @(negedge clk);
        if (uart_txd === 1'b0) begin
            wait_clks(BIT_CLKS / 2);
            mon_ok = (uart_txd === 1'b0);
            for (int i = 0; i < 8; i++) begin
                wait_clks(BIT_CLKS);
                mon_b[i] = uart_txd;
            end
            wait_clks(BIT_CLKS);
            mon_ok = mon_ok & (uart_txd === 1'b1);
            tx_q.push_back({mon_ok, mon_b});
        end
    end

    task automatic check_tx_frame(input string name, input logic [7:0] b);
        if (tx_q.size() == 0) begin
            check(name, 32'h0, {23'd0, 1'b1, b});
        end else begin
            check(name, {23'd0, tx_q.pop_front()}, {23'd0, 1'b1, b});
        end
    endtask

    typedef struct {
        logic [31:0] a;
        logic        exp_sel;
        logic [31:0] exp_rdata;
    } vec_t;

    vec_t vecs[8];
    int   lo_len;
    int   wcnt;

    initial begin
        #2000000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        logic [7:0]  b;
        logic [7:0]  m_byte;
        logic        m_avail;
        logic        m_ovr;
        logic [31:0] d;

        vecs[0] = '{32'h40000018, 1'b1, 32'h0};
        vecs[1] = '{32'h4000001B, 1'b1, 32'h0};
        vecs[2] = '{32'h4000001C, 1'b1, 32'h0};
        vecs[3] = '{32'h40000022, 1'b1, 32'h0};
        vecs[4] = '{32'h40000024, 1'b0, 32'h0};
        vecs[5] = '{32'h40000014, 1'b0, 32'h0};
        vecs[6] = '{32'hC0000018, 1'b0, 32'h0};
        vecs[7] = '{32'h00000000, 1'b0, 32'h0};

        wait_clks(5);
        reset = 1'b0;
        wait_clks(2);
        check("reset_txd", {31'd0, uart_txd}, 32'h1);
        for (int i = 0; i < 8; i++) begin
            @(negedge clk);
            addr = vecs[i].a;
            #1;
            check($sformatf("decode_sel[%0d]", i), {31'd0, sel}, {31'd0, vecs[i].exp_sel});
            check($sformatf("decode_rdata[%0d]", i), rdata, vecs[i].exp_rdata);
        end
        addr = '0;

        // Basic receive and pop.
        send_rx(8'h5A, 1'b0);
        wait_clks(20);
        rd_check("rx_con_avail", A_CON, 32'h3);
        rd_check("rx_byte_5a", A_RXD, 32'h5A);
        rd_check("rx_con_popped", A_CON, 32'h0);

        // Transmit with start-bit width measurement.
        fork
            begin
                bus_wr(A_TXD, 32'h000000C3);
                rd_check("tx_con_busy", A_CON, 32'h4);
            end
            begin
                wcnt = 0;
                lo_len = 0;
                while (uart_txd !== 1'b0 && wcnt < 200) begin
                    @(negedge clk);
                    wcnt++;
                end
                while (uart_txd === 1'b0 && lo_len < 400) begin
                    @(negedge clk);
                    lo_len++;
                end
                check("tx_start_len", 32'(lo_len >= 150 && lo_len <= 170), 32'h1);
            end
        join
        wait_tx_idle("tx_c3_idle");
        wait_clks(20);
        check_tx_frame("tx_frame_c3", 8'hC3);
        rd_check("tx_con_idle", A_CON, 32'h0);
        rd_check("tx_last_c3", A_TXD, 32'hC3);

        // Overrun keeps the first byte; CON write clears OVR.
        send_rx(8'h11, 1'b0);
        send_rx(8'h22, 1'b0);
        wait_clks(20);
        rd_check("ovr_con", A_CON, 32'hB);
        rd_check("ovr_keeps_first", A_RXD, 32'h11);
        bus_wr(A_CON, 32'h8);
        rd_check("ovr_cleared", A_CON, 32'h0);

        // Framing error, then a short glitch.
        send_rx(8'h55, 1'b1);
        wait_clks(200);
        rd_check("ferr_con", A_CON, 32'h10);
        bus_wr(A_CON, 32'h0);
        rd_check("ferr_write0_noeffect", A_CON, 32'h10);
        bus_wr(A_CON, 32'h10);
        rd_check("ferr_cleared", A_CON, 32'h0);
        rxd_drv = 1'b0;
        wait_clks(60);
        rxd_drv = 1'b1;
        wait_clks(2000);
        rd_check("glitch_ignored", A_CON, 32'h0);

        // Store while busy is dropped; loopback delivers the first byte.
        loop_en = 1'b1;
        bus_wr(A_TXD, 32'h41);
        bus_wr(A_TXD, 32'h42);
        rd_check("busy_store_ignored", A_TXD, 32'h41);
        wait_tx_idle("tx_41_idle");
        wait_clks(20);
        rd_check("loop_rx_41", A_RXD, 32'h41);
        rd_check("loop_con_clear", A_CON, 32'h0);
        wait_clks(2000);
        check("tx_frame_count", 32'(tx_q.size()), 32'h1);
        check_tx_frame("tx_frame_41", 8'h41);
        loop_en = 1'b0;

        // Reset in the middle of both frames.
        bus_wr(A_TXD, 32'h00);
        rxd_drv = 1'b0;
        wait_clks(500);
        check("pre_reset_txd_low", {31'd0, uart_txd}, 32'h0);
        reset = 1'b1;
        rxd_drv = 1'b1;
        @(negedge clk);
        check("reset_mid_txd", {31'd0, uart_txd}, 32'h1);
        reset = 1'b0;
        rd_check("reset_con", A_CON, 32'h0);
        rd_check("reset_rxd", A_RXD, 32'h0);
        rd_check("reset_txd_reg", A_TXD, 32'h0);
        wait_clks(2500);
        tx_q.delete();
        b = 8'($urandom);
        send_rx(b, 1'b0);
        wait_clks(20);
        rd_check("post_reset_con", A_CON, 32'h3);
        rd_check("post_reset_rx", A_RXD, {24'd0, b});

        // Random loopback traffic.
        loop_en = 1'b1;
        for (int i = 0; i < 4; i++) begin
            b = 8'($urandom);
            bus_wr(A_TXD, {24'd0, b});
            wait_tx_idle("rand_tx_idle");
            wait_clks(20);
            rd_check("rand_loop_con", A_CON, 32'h3);
            rd_check("rand_loop_rx", A_RXD, {24'd0, b});
            check_tx_frame("rand_tx_frame", b);
        end
        loop_en = 1'b0;

        // Random RX with occasional polling: the oldest unread byte survives, later ones overrun.
        m_avail = 1'b0;
        m_ovr = 1'b0;
        m_byte = 8'd0;
        for (int i = 0; i < 6; i++) begin
            b = 8'($urandom);
            send_rx(b, 1'b0);
            wait_clks(20 + $urandom_range(0, 40));
            if (!m_avail) begin
                m_byte = b;
                m_avail = 1'b1;
            end else begin
                m_ovr = 1'b1;
            end
            if ($urandom_range(0, 1) == 1 || i == 5) begin
                rd_check("rand_rx_con", A_CON, {28'd0, m_ovr, 1'b0, m_avail, m_avail});
                rd_check("rand_rx_byte", A_RXD, {24'd0, m_byte});
                m_avail = 1'b0;
            end
        end
        bus_wr(A_CON, 32'h18);
        rd_check("final_con", A_CON, 32'h0);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
